// File: rtl/midi_io_pkg.sv
// Shared MIDI constants, state encodings and the status-byte length decoder.
package midi_io_pkg;

  localparam logic [7:0] MIDI_CC = 8'hB0;
  localparam logic [7:0] MIDI_PC = 8'hC0;

  localparam logic [7:0] TX_BITS_1B = 8'd10;
  localparam logic [7:0] TX_BITS_2B = 8'd20;
  localparam logic [7:0] TX_BITS_3B = 8'd30;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Data bytes that follow a status byte (running status is not supported).
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    case (status[7:4])
      4'hC, 4'hD: return 2'd1;
      4'hF:       return 2'd0;
      default:    return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/midi_debounce.sv
// Level debouncer: the output follows the input only after it has differed
// from the output for 2^CNT_W consecutive cycles.
module midi_debounce #(
  parameter int CNT_W = 21
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic level_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (level_i == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == '1) begin
      level_d = level_i;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/midi_io_core.sv
// MIDI front end: footswitch debouncing, 31250-baud TX shifter, RX framer with
// command assembly, and save-mode tracking for assigning commands to buttons.
module midi_io_core
  import midi_io_pkg::*;
#(
  parameter int BAUD_CNT_HALF = 1600,
  parameter int DEBOUNCE_CNT  = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn1,
  input  logic       btn2,
  input  logic       midi_rx,
  output logic       midi_tx,
  input  logic [7:0] tx_status,
  input  logic [7:0] tx_data1,
  input  logic [7:0] tx_data2,
  input  logic [7:0] tx_bits,
  input  logic       tx_trigger,
  output logic       tx_busy,
  output logic [7:0] rx_status,
  output logic [7:0] rx_data1,
  output logic [7:0] rx_data2,
  output logic [1:0] rx_bytes,
  output logic       rx_valid,
  output logic [1:0] btn_index,
  output logic       save_mode
);

  localparam int BAUD_W = (2 * BAUD_CNT_HALF > 2) ? $clog2(2 * BAUD_CNT_HALF) : 1;
  localparam logic [BAUD_W-1:0] BIT_END  = BAUD_W'(2 * BAUD_CNT_HALF - 1);
  localparam logic [BAUD_W-1:0] HALF_END = BAUD_W'(BAUD_CNT_HALF - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE = BAUD_W'(1);

  logic [1:0] btn1_s_q, btn2_s_q, rx_s_q;
  logic       rx_sync, rx_prev_q;
  logic       db1, db2, db_any_q;
  logic [1:0] btn_index_q;

  midi_debounce #(.CNT_W(DEBOUNCE_CNT)) u_db1 (
    .clk_i(clk), .rst_ni(rst), .level_i(btn1_s_q[1]), .level_o(db1)
  );
  midi_debounce #(.CNT_W(DEBOUNCE_CNT)) u_db2 (
    .clk_i(clk), .rst_ni(rst), .level_i(btn2_s_q[1]), .level_o(db2)
  );

  assign rx_sync = rx_s_q[1];

  // TX: the start bit of the first byte lives in the line register; the
  // shifter holds the remaining 29 line bits.
  logic        trig_q;
  logic        tx_busy_q, tx_busy_d, tx_line_q, tx_line_d;
  logic [28:0] tx_sh_q, tx_sh_d;
  logic [4:0]  tx_left_q, tx_left_d, tx_bits_n;
  logic [BAUD_W-1:0] tx_cnt_q, tx_cnt_d;

  assign tx_bits_n = (tx_bits > TX_BITS_3B) ? 5'd30 : tx_bits[4:0];

  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_line_d = tx_line_q;
    tx_sh_d   = tx_sh_q;
    tx_left_d = tx_left_q;
    tx_cnt_d  = tx_cnt_q;
    if (!tx_busy_q) begin
      tx_line_d = 1'b1;
      if (tx_trigger && !trig_q && tx_bits_n != 5'd0) begin
        tx_busy_d = 1'b1;
        tx_line_d = 1'b0;
        tx_sh_d   = {1'b1, tx_data2, 1'b0, 1'b1, tx_data1, 1'b0, 1'b1, tx_status};
        tx_left_d = tx_bits_n;
        tx_cnt_d  = '0;
      end
    end else if (tx_cnt_q == BIT_END) begin
      tx_cnt_d = '0;
      if (tx_left_q == 5'd1) begin
        tx_busy_d = 1'b0;
        tx_line_d = 1'b1;
      end else begin
        tx_left_d = tx_left_q - 5'd1;
        tx_line_d = tx_sh_q[0];
        tx_sh_d   = {1'b1, tx_sh_q[28:1]};
      end
    end else begin
      tx_cnt_d = tx_cnt_q + BAUD_ONE;
    end
  end

  // RX framer: counters are re-zeroed at mid-start so later samples land mid-bit.
  rx_state_e         rx_state_q, rx_state_d;
  logic [BAUD_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_sh_q, rx_sh_d;
  logic              byte_done;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    byte_done  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + BAUD_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_sync, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + BAUD_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          byte_done  = rx_sync;
        end else begin
          rx_cnt_d = rx_cnt_q + BAUD_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Command assembly and save-mode bookkeeping.
  logic       pend_q, pend_d, got_q, got_d, assigned_q, assigned_d;
  logic [1:0] need_q, need_d, rx_bytes_q, rx_bytes_d;
  logic [7:0] cmd_st_q, cmd_st_d, cmd_d1_q, cmd_d1_d;
  logic [7:0] rx_status_q, rx_status_d, rx_data1_q, rx_data1_d, rx_data2_q, rx_data2_d;
  logic       rx_valid_q, rx_valid_d;

  always_comb begin
    pend_d      = pend_q;
    got_d       = got_q;
    need_d      = need_q;
    cmd_st_d    = cmd_st_q;
    cmd_d1_d    = cmd_d1_q;
    rx_status_d = rx_status_q;
    rx_data1_d  = rx_data1_q;
    rx_data2_d  = rx_data2_q;
    rx_bytes_d  = rx_bytes_q;
    rx_valid_d  = rx_valid_q;
    if (byte_done) begin
      if (rx_sh_q[7]) begin
        rx_valid_d = 1'b0;
        pend_d     = 1'b0;
        if (midi_data_len(rx_sh_q) == 2'd0) begin
          {rx_status_d, rx_data1_d, rx_data2_d} = {rx_sh_q, 16'h0000};
          rx_bytes_d = 2'd1;
          rx_valid_d = 1'b1;
        end else begin
          pend_d   = 1'b1;
          got_d    = 1'b0;
          need_d   = midi_data_len(rx_sh_q);
          cmd_st_d = rx_sh_q;
        end
      end else if (pend_q) begin
        if (!got_q && need_q == 2'd1) begin
          {rx_status_d, rx_data1_d, rx_data2_d} = {cmd_st_q, rx_sh_q, 8'h00};
          rx_bytes_d = 2'd2;
          rx_valid_d = 1'b1;
          pend_d     = 1'b0;
        end else if (!got_q) begin
          cmd_d1_d = rx_sh_q;
          got_d    = 1'b1;
        end else begin
          {rx_status_d, rx_data1_d, rx_data2_d} = {cmd_st_q, cmd_d1_q, rx_sh_q};
          rx_bytes_d = 2'd3;
          rx_valid_d = 1'b1;
          pend_d     = 1'b0;
        end
      end
    end
  end

  always_comb begin
    assigned_d = assigned_q;
    if (!rx_valid_q) assigned_d = 1'b0;
    else if (save_mode && btn_index_q != 2'd0) assigned_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn1_s_q <= 2'b00;       btn2_s_q <= 2'b00;
      rx_s_q <= 2'b11;         rx_prev_q <= 1'b1;
      db_any_q <= 1'b0;        btn_index_q <= 2'd0;
      trig_q <= 1'b0;          tx_busy_q <= 1'b0;
      tx_line_q <= 1'b1;       tx_sh_q <= '1;
      tx_left_q <= 5'd0;       tx_cnt_q <= '0;
      rx_state_q <= RX_IDLE;   rx_cnt_q <= '0;
      rx_bit_q <= 3'd0;        rx_sh_q <= 8'h00;
      pend_q <= 1'b0;          got_q <= 1'b0;
      need_q <= 2'd0;          cmd_st_q <= 8'h00;
      cmd_d1_q <= 8'h00;       rx_status_q <= 8'h00;
      rx_data1_q <= 8'h00;     rx_data2_q <= 8'h00;
      rx_bytes_q <= 2'd0;      rx_valid_q <= 1'b0;
      assigned_q <= 1'b0;
    end else begin
      btn1_s_q <= {btn1_s_q[0], btn1};
      btn2_s_q <= {btn2_s_q[0], btn2};
      rx_s_q <= {rx_s_q[0], midi_rx};
      rx_prev_q <= rx_sync;
      db_any_q <= db1 | db2;
      btn_index_q <= ((db1 | db2) && !db_any_q) ? {db2, db1} : 2'd0;
      trig_q <= tx_trigger;      tx_busy_q <= tx_busy_d;
      tx_line_q <= tx_line_d;    tx_sh_q <= tx_sh_d;
      tx_left_q <= tx_left_d;    tx_cnt_q <= tx_cnt_d;
      rx_state_q <= rx_state_d;  rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;      rx_sh_q <= rx_sh_d;
      pend_q <= pend_d;          got_q <= got_d;
      need_q <= need_d;          cmd_st_q <= cmd_st_d;
      cmd_d1_q <= cmd_d1_d;      rx_status_q <= rx_status_d;
      rx_data1_q <= rx_data1_d;  rx_data2_q <= rx_data2_d;
      rx_bytes_q <= rx_bytes_d;  rx_valid_q <= rx_valid_d;
      assigned_q <= assigned_d;
    end
  end

  assign midi_tx   = tx_line_q;
  assign tx_busy   = tx_busy_q;
  assign rx_status = rx_status_q;
  assign rx_data1  = rx_data1_q;
  assign rx_data2  = rx_data2_q;
  assign rx_bytes  = rx_bytes_q;
  assign rx_valid  = rx_valid_q;
  assign btn_index = btn_index_q;
  assign save_mode = rx_valid_q & ~assigned_q;

endmodule

// File: tb/tb_midi_io_core.sv
// Directed bench for midi_io_core with a short baud period and debounce window.
`timescale 1ns/1ps
module tb_midi_io_core;

  localparam int HALF    = 4;
  localparam int DB      = 3;
  localparam int BIT_CYC = 2 * HALF;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn1, btn2, midi_rx, midi_tx;
  logic [7:0] tx_status, tx_data1, tx_data2, tx_bits;
  logic       tx_trigger, tx_busy;
  logic [7:0] rx_status, rx_data1, rx_data2;
  logic [1:0] rx_bytes, btn_index;
  logic       rx_valid, save_mode;

  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  midi_io_core #(.BAUD_CNT_HALF(HALF), .DEBOUNCE_CNT(DB)) dut (
    .clk(clk), .rst(rst), .btn1(btn1), .btn2(btn2),
    .midi_rx(midi_rx), .midi_tx(midi_tx),
    .tx_status(tx_status), .tx_data1(tx_data1), .tx_data2(tx_data2),
    .tx_bits(tx_bits), .tx_trigger(tx_trigger), .tx_busy(tx_busy),
    .rx_status(rx_status), .rx_data1(rx_data1), .rx_data2(rx_data2),
    .rx_bytes(rx_bytes), .rx_valid(rx_valid),
    .btn_index(btn_index), .save_mode(save_mode)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: one TX request, line checked at first and last cycle of every bit
  task automatic run_tx(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [7:0] bits, input int nbits, input bit retrig);
    logic [7:0] bytes_a [3];
    logic [0:0] cur;
    cur = 1'b1;
    bytes_a[0] = s; bytes_a[1] = d1; bytes_a[2] = d2;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(bytes_a[k][i]);
      exp_q.push_back(1'b1);
    end
    @(negedge clk);
    tx_status = s; tx_data1 = d1; tx_data2 = d2; tx_bits = bits; tx_trigger = 1'b1;
    for (int c = 0; c < nbits * BIT_CYC; c++) begin
      @(negedge clk);
      if (retrig && c == 10) tx_trigger = 1'b0;
      if (retrig && c == 50) begin
        tx_trigger = 1'b1; tx_status = 8'h00; tx_data1 = 8'hFF;
      end
      if (c % BIT_CYC == 0) cur = exp_q.pop_front();
      if (c % BIT_CYC == 0 || c % BIT_CYC == BIT_CYC - 1)
        check($sformatf("tx_bit%0d_c%0d", c / BIT_CYC, c % BIT_CYC), midi_tx, cur);
      if (c == 0 || c == nbits * BIT_CYC - 1) check("tx_busy_run", tx_busy, 1);
    end
    @(negedge clk);
    check("tx_busy_done", tx_busy, 0);
    check("tx_line_done", midi_tx, 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("tx_idle_busy", tx_busy, 0);
      check("tx_idle_line", midi_tx, 1);
    end
    tx_trigger = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // driver: one RX frame, each bit held BIT_CYC cycles, then an idle gap
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    midi_rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (BIT_CYC) @(negedge clk);
      midi_rx = b[i];
    end
    repeat (BIT_CYC) @(negedge clk);
    midi_rx = stop_bit;
    repeat (BIT_CYC) @(negedge clk);
    midi_rx = 1'b1;
    repeat (2 * BIT_CYC) @(negedge clk);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] st, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [1:0] nb);
    check({tag, "_status"}, rx_status, st);
    check({tag, "_data1"}, rx_data1, d1);
    check({tag, "_data2"}, rx_data2, d2);
    check({tag, "_bytes"}, rx_bytes, nb);
    check({tag, "_valid"}, rx_valid, 1);
  endtask

  initial begin
    int n_pulse, n_other, pulse_at;
    logic save_at, save_after;

    rst = 1'b0; btn1 = 1'b0; btn2 = 1'b0; midi_rx = 1'b1;
    tx_status = 8'h00; tx_data1 = 8'h00; tx_data2 = 8'h00; tx_bits = 8'd0; tx_trigger = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("reset_midi_tx", midi_tx, 1);
    check("reset_tx_busy", tx_busy, 0);
    check("reset_btn_index", btn_index, 0);
    check("reset_save_mode", save_mode, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_fields", {rx_status, rx_data1, rx_data2, 6'd0, rx_bytes}, 0);

    // TX
    run_tx(8'hB0, 8'h2E, 8'h7F, 8'd30, 30, 1'b1);
    run_tx(8'hC0, 8'h42, 8'h00, 8'd20, 20, 1'b0);
    run_tx(8'hF8, 8'h00, 8'h00, 8'd10, 10, 1'b0);
    run_tx(8'h90, 8'h3C, 8'h40, 8'd40, 30, 1'b0);
    run_tx(8'h90, 8'h3C, 8'h40, 8'd0, 0, 1'b0);

    // RX
    send_byte(8'h12, 1'b1);
    check("rx_orphan_data", rx_valid, 0);
    send_byte(8'hB0, 1'b1);
    send_byte(8'h2E, 1'b1);
    check("rx_partial", rx_valid, 0);
    send_byte(8'h7F, 1'b1);
    check_rx("rx_cc", 8'hB0, 8'h2E, 8'h7F, 2'd3);
    check("rx_cc_save", save_mode, 1);
    send_byte(8'hF8, 1'b1);
    check_rx("rx_rt", 8'hF8, 8'h00, 8'h00, 2'd1);
    send_byte(8'h90, 1'b1);
    check("rx_status_clears", rx_valid, 0);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC5, 1'b1);
    send_byte(8'h01, 1'b1);
    check_rx("rx_abort", 8'hC5, 8'h01, 8'h00, 2'd2);
    send_byte(8'hC0, 1'b1);
    check("rx_pc_pending", rx_valid, 0);
    check("rx_pc_pending_save", save_mode, 0);
    send_byte(8'h55, 1'b0);
    check("rx_bad_stop", rx_valid, 0);
    send_byte(8'h43, 1'b1);
    check_rx("rx_pc", 8'hC0, 8'h43, 8'h00, 2'd2);
    check("rx_pc_save", save_mode, 1);

    // save mode: bouncing btn2, then hold
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      btn2 = (i % 2 == 1);
    end
    @(negedge clk);
    btn2 = 1'b1;
    n_pulse = 0; n_other = 0; pulse_at = -1; save_at = 1'b0; save_after = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (pulse_at >= 0 && c == pulse_at + 1) save_after = save_mode;
      if (btn_index == 2'd2) begin
        n_pulse++; pulse_at = c; save_at = save_mode;
      end else if (btn_index != 2'd0) n_other++;
    end
    check("btn2_pulse_count", n_pulse, 1);
    check("btn2_other_count", n_other, 0);
    check("btn2_latency_ok", (pulse_at >= 8 && pulse_at <= 11), 1);
    check("btn2_save_at_pulse", save_at, 1);
    check("btn2_save_after", save_after, 0);
    check("btn2_valid_kept", rx_valid, 1);
    btn2 = 1'b0;
    n_other = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (btn_index != 2'd0) n_other++;
    end
    check("btn2_release_quiet", n_other, 0);
    send_byte(8'hC0, 1'b1);
    check("rearm_valid_low", rx_valid, 0);
    send_byte(8'h43, 1'b1);
    check("rearm_valid", rx_valid, 1);
    check("rearm_save", save_mode, 1);

    // both buttons in the same cycle
    @(negedge clk);
    btn1 = 1'b1; btn2 = 1'b1;
    n_pulse = 0; n_other = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (btn_index == 2'd3) n_pulse++;
      else if (btn_index != 2'd0) n_other++;
    end
    check("both_pulse_count", n_pulse, 1);
    check("both_other_count", n_other, 0);
    check("both_assigned", save_mode, 0);
    btn1 = 1'b0; btn2 = 1'b0;
    repeat (20) @(negedge clk);

    // reset in the middle of a transmission
    tx_status = 8'hB0; tx_data1 = 8'h00; tx_data2 = 8'h00; tx_bits = 8'd30; tx_trigger = 1'b1;
    repeat (20) @(negedge clk);
    check("pre_reset_busy", tx_busy, 1);
    rst = 1'b0;
    #1;
    check("mid_reset_tx", midi_tx, 1);
    check("mid_reset_busy", tx_busy, 0);
    check("mid_reset_valid", rx_valid, 0);
    check("mid_reset_rx_status", rx_status, 0);
    check("mid_reset_rx_bytes", rx_bytes, 0);
    tx_trigger = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("post_reset_tx", midi_tx, 1);
    check("post_reset_busy", tx_busy, 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
